pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the pipelined MIPS datapath. Generalises the fixed EX/MEM-style register.
- Carries a control bundle and a data bundle through STAGES register slices, with a per-slice valid bit.
- Adds a global stall (hold), per-slice flush (bubble insertion) and saturating stall/flush event counters for the hazard unit and debug.

---
 rtl/pipe_stage_reg.sv | 92 +++++++++
 tb/tb_pipe_stage_reg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with hold, per-slice flush
// and saturating stall/flush event counters.
module pipe_stage_reg #(
  parameter int CTRL_W     = 3,
  parameter int DATA_W     = 69,
  parameter int STAGES     = 1,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_stall,
  input  logic [STAGES-1:0] i_flush,
  input  logic              i_cnt_clr,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [STAGES-1:0] o_stage_valid,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  logic [STAGES-1:0]             r_valid;
  logic [STAGES-1:0][CTRL_W-1:0] r_ctrl;
  logic [STAGES-1:0][DATA_W-1:0] r_data;
  logic [CNT_W-1:0]              r_stall_cnt;
  logic [CNT_W-1:0]              r_flush_cnt;

  logic [STAGES-1:0]             w_in_valid;
  logic [STAGES-1:0][CTRL_W-1:0] w_in_ctrl;
  logic [STAGES-1:0][DATA_W-1:0] w_in_data;
  logic                          w_any_flush;

  assign w_in_valid[0] = i_valid;
  assign w_in_ctrl[0]  = i_ctrl;
  assign w_in_data[0]  = i_data;

  for (genvar k = 1; k < STAGES; k++) begin : g_chain
    assign w_in_valid[k] = r_valid[k-1];
    assign w_in_ctrl[k]  = r_ctrl[k-1];
    assign w_in_data[k]  = r_data[k-1];
  end

  assign w_any_flush = |i_flush;

  // Flush wins over stall only for the flushed slice itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (i_flush[k]) begin
          r_valid[k] <= 1'b0;
          r_ctrl[k]  <= '0;
          if (CLEAR_DATA != 0) r_data[k] <= '0;
        end else if (!i_stall) begin
          r_valid[k] <= w_in_valid[k];
          r_ctrl[k]  <= w_in_ctrl[k];
          r_data[k]  <= w_in_data[k];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_stall && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_any_flush && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_valid       = r_valid[STAGES-1];
  assign o_ctrl        = r_ctrl[STAGES-1];
  assign o_data        = r_data[STAGES-1];
  assign o_stage_valid = r_valid;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three parameterisations driven in lockstep
// and compared every cycle against a slice-level behavioural model.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst_n;
  logic        iv;
  logic [2:0]  ictrl;
  logic [68:0] idata;
  logic        stall;
  logic [2:0]  flush3;
  logic [1:0]  flush2;
  logic        clr;

  logic        o3_v, o2a_v, o2b_v;
  logic [2:0]  o3_c, o2a_c, o2b_c;
  logic [68:0] o3_d, o2a_d, o2b_d;
  logic [2:0]  o3_sv;
  logic [1:0]  o2a_sv, o2b_sv;
  logic [15:0] o3_sc, o3_fc, o2a_sc, o2a_fc;
  logic [3:0]  o2b_sc, o2b_fc;

  int n_tot;
  int n_pass;

  pipe_stage_reg #(.CTRL_W(3), .DATA_W(69), .STAGES(3),
                   .CLEAR_DATA(0), .CNT_W(16)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv), .i_ctrl(ictrl),
    .i_data(idata), .i_stall(stall), .i_flush(flush3), .i_cnt_clr(clr),
    .o_valid(o3_v), .o_ctrl(o3_c), .o_data(o3_d), .o_stage_valid(o3_sv),
    .o_stall_cnt(o3_sc), .o_flush_cnt(o3_fc));

  pipe_stage_reg #(.CTRL_W(3), .DATA_W(69), .STAGES(2),
                   .CLEAR_DATA(0), .CNT_W(16)) u2a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv), .i_ctrl(ictrl),
    .i_data(idata), .i_stall(stall), .i_flush(flush2), .i_cnt_clr(clr),
    .o_valid(o2a_v), .o_ctrl(o2a_c), .o_data(o2a_d), .o_stage_valid(o2a_sv),
    .o_stall_cnt(o2a_sc), .o_flush_cnt(o2a_fc));

  pipe_stage_reg #(.CTRL_W(3), .DATA_W(69), .STAGES(2),
                   .CLEAR_DATA(1), .CNT_W(4)) u2b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv), .i_ctrl(ictrl),
    .i_data(idata), .i_stall(stall), .i_flush(flush2), .i_cnt_clr(clr),
    .o_valid(o2b_v), .o_ctrl(o2b_c), .o_data(o2b_d), .o_stage_valid(o2b_sv),
    .o_stall_cnt(o2b_sc), .o_flush_cnt(o2b_fc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: per instance, an array of slices plus two counters.
  int          m_s[3]   = '{3, 2, 2};
  int          m_clr[3] = '{0, 0, 1};
  int          m_max[3] = '{65535, 65535, 15};
  logic        m_v[3][8];
  logic [2:0]  m_c[3][8];
  logic [68:0] m_d[3][8];
  int          m_sc[3];
  int          m_fc[3];

  task automatic model_clear();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 8; k++) begin
        m_v[n][k] = 1'b0;
        m_c[n][k] = '0;
        m_d[n][k] = '0;
      end
      m_sc[n] = 0;
      m_fc[n] = 0;
    end
  endtask

  task automatic model_step();
    logic fl;
    logic anyf;
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int n = 0; n < 3; n++) begin
      anyf = 1'b0;
      // Walk from the output end so each slice sees its neighbour's old value.
      for (int k = m_s[n] - 1; k >= 0; k--) begin
        fl = (n == 0) ? flush3[k] : flush2[k];
        anyf = anyf | fl;
        if (fl) begin
          m_v[n][k] = 1'b0;
          m_c[n][k] = '0;
          if (m_clr[n] != 0) m_d[n][k] = '0;
        end else if (!stall) begin
          m_v[n][k] = (k == 0) ? iv    : m_v[n][k-1];
          m_c[n][k] = (k == 0) ? ictrl : m_c[n][k-1];
          m_d[n][k] = (k == 0) ? idata : m_d[n][k-1];
        end
      end
      if (clr) begin
        m_sc[n] = 0;
        m_fc[n] = 0;
      end else begin
        if (stall && m_sc[n] < m_max[n]) m_sc[n]++;
        if (anyf && m_fc[n] < m_max[n]) m_fc[n]++;
      end
    end
  endtask

  function automatic logic [68:0] m_sv(int n);
    logic [68:0] r;
    r = '0;
    for (int k = 0; k < m_s[n]; k++) r[k] = m_v[n][k];
    return r;
  endfunction

  task automatic chk(string nm, logic [68:0] act, logic [68:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic compare_all();
    chk("u3 valid",  69'(o3_v),   69'(m_v[0][2]));
    chk("u3 ctrl",   69'(o3_c),   69'(m_c[0][2]));
    chk("u3 data",   o3_d,        m_d[0][2]);
    chk("u3 sv",     69'(o3_sv),  m_sv(0));
    chk("u3 scnt",   69'(o3_sc),  69'(m_sc[0]));
    chk("u3 fcnt",   69'(o3_fc),  69'(m_fc[0]));
    chk("u2a valid", 69'(o2a_v),  69'(m_v[1][1]));
    chk("u2a ctrl",  69'(o2a_c),  69'(m_c[1][1]));
    chk("u2a data",  o2a_d,       m_d[1][1]);
    chk("u2a sv",    69'(o2a_sv), m_sv(1));
    chk("u2a scnt",  69'(o2a_sc), 69'(m_sc[1]));
    chk("u2a fcnt",  69'(o2a_fc), 69'(m_fc[1]));
    chk("u2b valid", 69'(o2b_v),  69'(m_v[2][1]));
    chk("u2b ctrl",  69'(o2b_c),  69'(m_c[2][1]));
    chk("u2b data",  o2b_d,       m_d[2][1]);
    chk("u2b sv",    69'(o2b_sv), m_sv(2));
    chk("u2b scnt",  69'(o2b_sc), 69'(m_sc[2]));
    chk("u2b fcnt",  69'(o2b_fc), 69'(m_fc[2]));
  endtask

  // One clock: model follows the edge, outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    iv = 1'b0; ictrl = '0; idata = '0;
    stall = 1'b0; flush3 = '0; flush2 = '0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  localparam logic [68:0] D1 = 69'h0_DEADBEEF_00000010_07;

  initial begin
    n_tot = 0;
    n_pass = 0;
    model_clear();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("reset o_valid",  69'(o3_v),  69'd0);
    chk("reset o_data",   o3_d,       69'd0);
    chk("reset stage_v",  69'(o3_sv), 69'd0);
    do_reset();

    // Latency with held inputs.
    iv = 1'b1; ictrl = 3'b101; idata = D1;
    cyc();
    chk("lat sv c1", 69'(o3_sv), 69'b001);
    cyc();
    chk("lat sv c2", 69'(o3_sv), 69'b011);
    chk("lat v c2",  69'(o3_v),  69'd0);
    cyc();
    chk("lat sv c3", 69'(o3_sv), 69'b111);
    chk("lat v c3",  69'(o3_v),  69'd1);
    chk("lat ctrl",  69'(o3_c),  69'(3'b101));
    chk("lat data",  o3_d,       D1);

    // Stall at the output: item 1 held for three samples, then 2, 3.
    do_reset();
    iv = 1'b1; ictrl = 3'b000;
    idata = 69'd1; cyc();
    idata = 69'd2; cyc();
    idata = 69'd3; cyc();
    chk("stall d0", o3_d, 69'd1);
    iv = 1'b0; idata = 69'd99; stall = 1'b1;
    cyc();
    chk("stall d1", o3_d, 69'd1);
    cyc();
    chk("stall d2", o3_d, 69'd1);
    stall = 1'b0;
    cyc();
    chk("stall d3", o3_d, 69'd2);
    cyc();
    chk("stall d4", o3_d, 69'd3);
    chk("stall cnt", 69'(o3_sc), 69'd2);

    // Flush of the last slice while stalled.
    do_reset();
    iv = 1'b1; ictrl = 3'b111; idata = 69'd5; cyc();
    ictrl = 3'b010; idata = 69'd9; cyc();
    chk("pre-flush ctrl", 69'(o2a_c), 69'(3'b111));
    stall = 1'b1; flush2 = 2'b10; ictrl = 3'b100; idata = 69'd44;
    cyc();
    chk("flush v",     69'(o2a_v),  69'd0);
    chk("flush ctrl",  69'(o2a_c),  69'd0);
    chk("flush keep",  o2a_d,       69'd5);
    chk("flush clr",   o2b_d,       69'd0);
    chk("flush sv",    69'(o2a_sv), 69'b01);
    chk("flush cnt",   69'(o2a_fc), 69'd1);
    stall = 1'b0; flush2 = 2'b00; iv = 1'b0;
    cyc();
    chk("held s0 data", o2a_d,      69'd9);
    chk("held s0 ctrl", 69'(o2a_c), 69'(3'b010));

    // Saturation of the 4-bit counter, then clear beats increment.
    stall = 1'b1;
    repeat (20) cyc();
    chk("sat cnt", 69'(o2b_sc), 69'd15);
    clr = 1'b1;
    cyc();
    chk("clr cnt", 69'(o2b_sc), 69'd0);
    clr = 1'b0; stall = 1'b0;

    // Asynchronous reset between edges while full and stalled.
    iv = 1'b1; ictrl = 3'b110;
    idata = 69'd11; cyc();
    idata = 69'd12; cyc();
    idata = 69'd13; cyc();
    stall = 1'b1; flush3 = 3'b010;
    cyc();
    flush3 = 3'b000;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst valid", 69'(o3_v),  69'd0);
    chk("arst ctrl",  69'(o3_c),  69'd0);
    chk("arst data",  o3_d,       69'd0);
    chk("arst sv",    69'(o3_sv), 69'd0);
    chk("arst scnt",  69'(o3_sc), 69'd0);
    chk("arst fcnt",  69'(o3_fc), 69'd0);
    model_clear();
    rst_n = 1'b1;
    stall = 1'b0;
    iv = 1'b1; ictrl = 3'b011; idata = 69'd77;
    cyc();
    iv = 1'b0; ictrl = '0; idata = '0;
    cyc();
    chk("post-rst c2", 69'(o3_v), 69'd0);
    cyc();
    chk("post-rst c3 v", 69'(o3_v), 69'd1);
    chk("post-rst c3 d", o3_d,      69'd77);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      iv     = 1'($urandom);
      ictrl  = 3'($urandom);
      idata  = {5'($urandom), 32'($urandom), 32'($urandom)};
      stall  = ($urandom_range(0, 3) == 0);
      flush3 = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0)};
      flush2 = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      clr    = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
